// File: rtl/bc_operand_seq_if.sv
// Handshake bundle between the lane sequencer, broadcast buffer and lane-0 FPU operand path
// for bc_operand_seq; the DUT uses the slave modport, the driving side uses master.
interface bc_operand_seq_if #(
  parameter int MaxBlen  = 32,
  parameter int RepWidth = 8,
  parameter int Elen     = 64
);
  localparam int IdxWidth = $clog2(MaxBlen);

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [IdxWidth:0]   cmd_blen_i;
  logic [RepWidth-1:0] cmd_reps_i;
  logic                bc_valid_i;
  logic [Elen-1:0]     bc_data_i;
  logic                bc_ready_o;
  logic                bc_invalidate_o;
  logic                op_valid_o;
  logic                op_ready_i;
  logic [31:0]         op_data_o;
  logic [IdxWidth-1:0] op_elem_idx_o;
  logic                op_last_o;
  logic                busy_o;
  logic [31:0]         stall_cnt_o;

  modport master (
    output cmd_valid_i, cmd_blen_i, cmd_reps_i, bc_valid_i, bc_data_i, op_ready_i,
    input  cmd_ready_o, bc_ready_o, bc_invalidate_o, op_valid_o, op_data_o,
           op_elem_idx_o, op_last_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  cmd_valid_i, cmd_blen_i, cmd_reps_i, bc_valid_i, bc_data_i, op_ready_i,
    output cmd_ready_o, bc_ready_o, bc_invalidate_o, op_valid_o, op_data_o,
           op_elem_idx_o, op_last_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/bc_operand_seq.sv
// Replays each broadcast element as a scalar fp32 operand for a programmed number of beats,
// then pulses the bank invalidate. Optional starvation counter: BC_OPSEQ_STALL_CNT_EN.
module bc_operand_seq #(
  parameter int MaxBlen  = 32,
  parameter int RepWidth = 8,
  parameter int Elen     = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  bc_operand_seq_if.slave bus
);
  localparam int IdxWidth  = $clog2(MaxBlen);
  localparam int BlenWidth = IdxWidth + 1;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_e;

  state_e               state, state_next;
  logic [BlenWidth-1:0] blen_q, blen_eff;
  logic [RepWidth-1:0]  reps_q, reps_eff, rep_cnt;
  logic [IdxWidth-1:0]  elem_idx;
  logic [31:0]          data_q;
  logic                 last_rep, final_elem;
  logic                 cmd_ready, bc_ready, op_valid, op_last, invalidate;
  logic                 bc_data_unused;

  assign bc_data_unused = ^bus.bc_data_i[Elen-1:32];

  assign blen_eff   = (bus.cmd_blen_i > BlenWidth'(MaxBlen)) ? BlenWidth'(MaxBlen) : bus.cmd_blen_i;
  assign reps_eff   = (bus.cmd_reps_i == '0) ? RepWidth'(1) : bus.cmd_reps_i;
  assign last_rep   = (rep_cnt == RepWidth'(1));
  assign final_elem = ({1'b0, elem_idx} == (blen_q - BlenWidth'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Pop and invalidate are suppressed during the reset cycle so an abort never touches the buffer.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    bc_ready   = 1'b0;
    op_valid   = 1'b0;
    op_last    = 1'b0;
    invalidate = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) state_next = (blen_eff == '0) ? DONE : FETCH;
      end
      FETCH: begin
        bc_ready = 1'b1;
        if (bus.bc_valid_i) state_next = ISSUE;
      end
      ISSUE: begin
        op_valid = 1'b1;
        op_last  = final_elem && last_rep;
        if (bus.op_ready_i && last_rep) begin
          if (final_elem) begin
            state_next = DONE;
          end else begin
            bc_ready = 1'b1;
            if (!bus.bc_valid_i) state_next = FETCH;
          end
        end
      end
      DONE: begin
        invalidate = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst_i) begin
      bc_ready   = 1'b0;
      invalidate = 1'b0;
    end
  end

  // Element index advances when a non-final element retires, whether or not the next one is ready yet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blen_q   <= '0;
      reps_q   <= '0;
      rep_cnt  <= '0;
      elem_idx <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            blen_q   <= blen_eff;
            reps_q   <= reps_eff;
            elem_idx <= '0;
          end
        end
        FETCH: begin
          if (bus.bc_valid_i) begin
            data_q  <= bus.bc_data_i[31:0];
            rep_cnt <= reps_q;
          end
        end
        ISSUE: begin
          if (bus.op_ready_i) begin
            rep_cnt <= rep_cnt - RepWidth'(1);
            if (last_rep && !final_elem) begin
              elem_idx <= elem_idx + IdxWidth'(1);
              if (bus.bc_valid_i) begin
                data_q  <= bus.bc_data_i[31:0];
                rep_cnt <= reps_q;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.bc_ready_o      = bc_ready;
  assign bus.bc_invalidate_o = invalidate;
  assign bus.op_valid_o      = op_valid;
  assign bus.op_last_o       = op_last;
  assign bus.op_data_o       = data_q;
  assign bus.op_elem_idx_o   = elem_idx;
  assign bus.busy_o          = (state != IDLE);

`ifdef BC_OPSEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic        stall_evt;

  assign stall_evt = !bus.bc_valid_i &&
                     ((state == FETCH) || ((state == ISSUE) && last_rep && bus.op_ready_i));

  always_ff @(posedge clk_i) begin
    if (rst_i)                                stall_cnt <= '0;
    else if (stall_evt && (stall_cnt != '1))  stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cnt_o = stall_cnt;
`else
  assign bus.stall_cnt_o = '0;
`endif
endmodule
